stack_ram_responder: RTL and testbench

//  Memory-side responder for the stack CPU's RAM bus (address/data/wren in, q out).

---
 rtl/stack_ram_pkg.sv | 35 +++
 rtl/dp_ram_core.sv | 37 +++
 rtl/stack_ram_responder.sv | 196 +++++++++++++++++++
 tb/tb_stack_ram_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ram_pkg.sv
// Shared definitions for the stack CPU RAM responder: MMIO offsets, host FSM states,
// and the MMIO register read mux.
package stack_ram_pkg;

   localparam logic [3:0] SEG1_OFS = 4'd0;
   localparam logic [3:0] SEG2_OFS = 4'd1;
   localparam logic [3:0] CYC_OFS  = 4'd2;
   localparam logic [3:0] MBOX_OFS = 4'd3;

   typedef enum logic [1:0] {
      H_IDLE,
      H_ACCESS,
      H_ACK,
      CLEAR
   } host_state_e;

   function automatic logic [15:0] mmio_read(
      input logic [3:0]  ofs,
      input logic [15:0] seg1,
      input logic [15:0] seg2,
      input logic [15:0] cyc,
      input logic [15:0] mbox
   );
      logic [15:0] rd;
      case (ofs)
         SEG1_OFS: rd = seg1;
         SEG2_OFS: rd = seg2;
         CYC_OFS:  rd = cyc;
         MBOX_OFS: rd = mbox;
         default:  rd = '0;
      endcase
      return rd;
   endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Two-port synchronous RAM: registered read, old data on read/write collision,
// port A write wins when both ports write the same word.
module dp_ram_core #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_a,
   input  logic [AW-1:0]    addr_a,
   input  logic [WIDTH-1:0] din_a,
   output logic [WIDTH-1:0] dout_a,
   input  logic             en_b,
   input  logic             we_b,
   input  logic [AW-1:0]    addr_b,
   input  logic [WIDTH-1:0] din_b,
   output logic [WIDTH-1:0] dout_b
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_a_q;
   logic [WIDTH-1:0] rd_b_q;

   // Port A write is issued after port B so it takes precedence on the same word.
   always_ff @(posedge clk) begin
      rd_a_q <= mem[addr_a];
      if (en_b) begin
         rd_b_q <= mem[addr_b];
         if (we_b) mem[addr_b] <= din_b;
      end
      if (we_a) mem[addr_a] <= din_a;
   end

   assign dout_a = rd_a_q;
   assign dout_b = rd_b_q;

endmodule

// File: rtl/stack_ram_responder.sv
// RAM bus responder for the stack CPU: 2-cycle read latency, MMIO window, host peek/poke port.
// Define STACK_RAM_CLEAR_EN to zero the RAM after every reset (ram_busy high meanwhile).
module stack_ram_responder
   import stack_ram_pkg::*;
#(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address_ram,
   input  logic [15:0] data_ram,
   input  logic        wren_ram,
   output logic [15:0] q_ram,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [15:0] host_wdata,
   output logic        host_ack,
   output logic [15:0] host_rdata,
   output logic [15:0] SEG1,
   output logic [15:0] SEG2,
   output logic        ram_busy
);

   localparam int unsigned AW = $clog2(DEPTH);

   host_state_e state_q, state_d;
   logic        h_we_q, h_we_d;
   logic [15:0] h_addr_q, h_addr_d;
   logic [15:0] h_wdata_q, h_wdata_d;
   logic [15:0] h_rd_q, h_rd_d;
   logic [15:0] seg1_q, seg1_d;
   logic [15:0] seg2_q, seg2_d;
   logic [15:0] cyc_q, cyc_d;
   logic [15:0] mbox_q, mbox_d;
   logic        cpu_mmio_q, cpu_mmio_d;
   logic [15:0] cpu_rd_q, cpu_rd_d;
   logic        cpu_zero_q, cpu_zero_d;
   logic [15:0] q_ram_q, q_ram_d;
`ifdef STACK_RAM_CLEAR_EN
   logic [AW-1:0] clr_idx_q, clr_idx_d;
`endif

   logic          cpu_mmio, host_mmio, host_access, busy;
   logic          ram_we_a, ram_en_b, ram_we_b;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [15:0]   ram_din_a, ram_rd_a, ram_rd_b;

   assign cpu_mmio    = (address_ram >= MMIO_BASE);
   assign host_mmio   = (h_addr_q >= MMIO_BASE);
   assign host_access = (state_q == H_ACCESS);
`ifdef STACK_RAM_CLEAR_EN
   assign busy = (state_q == CLEAR);
`else
   assign busy = 1'b0;
`endif

   dp_ram_core #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_ram (
      .clk    (clock),
      .we_a   (ram_we_a),
      .addr_a (ram_addr_a),
      .din_a  (ram_din_a),
      .dout_a (ram_rd_a),
      .en_b   (ram_en_b),
      .we_b   (ram_we_b),
      .addr_b (ram_addr_b),
      .din_b  (h_wdata_q),
      .dout_b (ram_rd_b)
   );

   always_comb begin
      state_d   = state_q;
      h_we_d    = h_we_q;
      h_addr_d  = h_addr_q;
      h_wdata_d = h_wdata_q;
      h_rd_d    = h_rd_q;
      seg1_d    = seg1_q;
      seg2_d    = seg2_q;
      mbox_d    = mbox_q;
      cyc_d     = cyc_q + 16'd1;

      // First pipeline stage captures decode and MMIO data; second selects onto q_ram.
      cpu_mmio_d = cpu_mmio;
      cpu_rd_d   = mmio_read(address_ram[3:0], seg1_q, seg2_q, cyc_q, mbox_q);
      cpu_zero_d = busy;
      q_ram_d    = cpu_mmio_q ? cpu_rd_q : (cpu_zero_q ? '0 : ram_rd_a);

      ram_we_a   = wren_ram && !cpu_mmio;
      ram_addr_a = address_ram[AW-1:0];
      ram_din_a  = data_ram;
      ram_en_b   = host_access && !reset;
      ram_we_b   = ram_en_b && h_we_q && !host_mmio;
      ram_addr_b = h_addr_q[AW-1:0];
`ifdef STACK_RAM_CLEAR_EN
      clr_idx_d = clr_idx_q;
      if (busy) begin
         ram_we_a   = 1'b1;
         ram_addr_a = clr_idx_q;
         ram_din_a  = '0;
      end
`endif

      // Host MMIO write applied first so a same-cycle CPU write overrides it.
      if (host_access && h_we_q && host_mmio) begin
         case (h_addr_q[3:0])
            SEG1_OFS: seg1_d = h_wdata_q;
            SEG2_OFS: seg2_d = h_wdata_q;
            MBOX_OFS: mbox_d = h_wdata_q;
            default: ;
         endcase
      end
      if (wren_ram && cpu_mmio) begin
         case (address_ram[3:0])
            SEG1_OFS: seg1_d = data_ram;
            SEG2_OFS: seg2_d = data_ram;
            MBOX_OFS: mbox_d = data_ram;
            default: ;
         endcase
      end
      if (host_access) h_rd_d = mmio_read(h_addr_q[3:0], seg1_q, seg2_q, cyc_q, mbox_q);

      case (state_q)
         H_IDLE: begin
            if (host_req) begin
               state_d   = H_ACCESS;
               h_we_d    = host_we;
               h_addr_d  = host_addr;
               h_wdata_d = host_wdata;
            end
         end
         H_ACCESS: state_d = H_ACK;
         H_ACK:    state_d = H_IDLE;
         CLEAR: begin
`ifdef STACK_RAM_CLEAR_EN
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DEPTH - 1)) state_d = H_IDLE;
`else
            state_d = H_IDLE;
`endif
         end
         default: state_d = H_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
`ifdef STACK_RAM_CLEAR_EN
         state_q   <= CLEAR;
         clr_idx_q <= '0;
`else
         state_q   <= H_IDLE;
`endif
         h_we_q     <= 1'b0;
         h_addr_q   <= '0;
         h_wdata_q  <= '0;
         h_rd_q     <= '0;
         seg1_q     <= '0;
         seg2_q     <= '0;
         cyc_q      <= '0;
         mbox_q     <= '0;
         cpu_mmio_q <= 1'b0;
         cpu_rd_q   <= '0;
         cpu_zero_q <= 1'b1;
         q_ram_q    <= '0;
      end else begin
         state_q    <= state_d;
`ifdef STACK_RAM_CLEAR_EN
         clr_idx_q  <= clr_idx_d;
`endif
         h_we_q     <= h_we_d;
         h_addr_q   <= h_addr_d;
         h_wdata_q  <= h_wdata_d;
         h_rd_q     <= h_rd_d;
         seg1_q     <= seg1_d;
         seg2_q     <= seg2_d;
         cyc_q      <= cyc_d;
         mbox_q     <= mbox_d;
         cpu_mmio_q <= cpu_mmio_d;
         cpu_rd_q   <= cpu_rd_d;
         cpu_zero_q <= cpu_zero_d;
         q_ram_q    <= q_ram_d;
      end
   end

   assign q_ram      = q_ram_q;
   assign SEG1       = seg1_q;
   assign SEG2       = seg2_q;
   assign ram_busy   = busy;
   assign host_ack   = (state_q == H_ACK);
   assign host_rdata = host_ack ? (host_mmio ? h_rd_q : ram_rd_b) : '0;

endmodule

// File: tb/tb_stack_ram_responder.sv
// Directed self-checking bench for stack_ram_responder; clear tests run when STACK_RAM_CLEAR_EN is defined.
module tb_stack_ram_responder;

`ifdef STACK_RAM_CLEAR_EN
   localparam int unsigned DEPTH = 16;
   localparam logic EXP_BUSY_RST = 1'b1;
   localparam logic [15:0] EXP_ABORT = 16'h0000;
`else
   localparam int unsigned DEPTH = 4096;
   localparam logic EXP_BUSY_RST = 1'b0;
   localparam logic [15:0] EXP_ABORT = 16'h1234;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address_ram = '0;
   logic [15:0] data_ram = '0;
   logic        wren_ram = 1'b0;
   logic [15:0] q_ram;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [15:0] host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic        host_ack;
   logic [15:0] host_rdata;
   logic [15:0] SEG1, SEG2;
   logic        ram_busy;

   int checks = 0;
   int errors = 0;
   logic [15:0] cyc_m;

   stack_ram_responder #(
      .DEPTH     (DEPTH),
      .MMIO_BASE (16'hFFF0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .address_ram (address_ram),
      .data_ram    (data_ram),
      .wren_ram    (wren_ram),
      .q_ram       (q_ram),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_ack    (host_ack),
      .host_rdata  (host_rdata),
      .SEG1        (SEG1),
      .SEG2        (SEG2),
      .ram_busy    (ram_busy)
   );

   always #5 clock = ~clock;

   // Reference free-running counter.
   always @(posedge clock) begin
      if (reset) cyc_m <= '0;
      else       cyc_m <= cyc_m + 16'd1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (ram_busy && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (ram_busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle ram_busy got %b exp 0", ram_busy);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      address_ram = a;
      data_ram = d;
      wren_ram = 1'b1;
      tick();
      wren_ram = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
      address_ram = a;
      wren_ram = 1'b0;
      tick();
      tick();
      d = q_ram;
   endtask

   task automatic host_xact(input logic we, input logic [15:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
      host_we = we;
      host_addr = a;
      host_wdata = wd;
      host_req = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!host_ack && lat < 40);
      rd = host_rdata;
      host_req = 1'b0;
      tick();
   endtask

   // Host access whose access edge coincides with a CPU write.
   task automatic host_with_cpu(input logic hwe, input logic [15:0] ha, input logic [15:0] hwd,
                                input logic [15:0] ca, input logic [15:0] cd,
                                output logic ack, output logic [15:0] rd);
      host_we = hwe;
      host_addr = ha;
      host_wdata = hwd;
      host_req = 1'b1;
      tick();
      address_ram = ca;
      data_ram = cd;
      wren_ram = 1'b1;
      tick();
      wren_ram = 1'b0;
      ack = host_ack;
      rd = host_rdata;
      host_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [15:0] d, exp;
      reset = 1'b1;
      address_ram = 16'hFFF3;
      tick();
      tick();
      checks++; if (q_ram !== 16'h0) begin errors++; $display("FAIL rst_q got %h exp 0000", q_ram); end
      checks++; if (SEG1 !== 16'h0) begin errors++; $display("FAIL rst_seg1 got %h exp 0000", SEG1); end
      checks++; if (SEG2 !== 16'h0) begin errors++; $display("FAIL rst_seg2 got %h exp 0000", SEG2); end
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", host_ack); end
      checks++; if (host_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0000", host_rdata); end
      checks++; if (ram_busy !== EXP_BUSY_RST) begin errors++; $display("FAIL rst_busy got %b exp %b", ram_busy, EXP_BUSY_RST); end
      reset = 1'b0;
      wait_idle();
      cpu_read(16'hFFF3, d);
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL rst_mbox got %h exp 0000", d); end
      exp = cyc_m;
      cpu_read(16'hFFF2, d);
      checks++; if (d !== exp) begin errors++; $display("FAIL rst_cyc got %h exp %h", d, exp); end
   endtask

   task automatic test_cpu_ram();
      logic [15:0] d;
      cpu_write(16'h0005, 16'h1234);
      cpu_write(16'h0006, 16'h0066);
      cpu_read(16'h0006, d);
      checks++; if (d !== 16'h0066) begin errors++; $display("FAIL rd6 got %h exp 0066", d); end
      address_ram = 16'h0005;
      tick();
      checks++; if (q_ram !== 16'h0066) begin errors++; $display("FAIL lat_hold got %h exp 0066", q_ram); end
      tick();
      checks++; if (q_ram !== 16'h1234) begin errors++; $display("FAIL rd5 got %h exp 1234", q_ram); end
      data_ram = 16'h5678;
      wren_ram = 1'b1;
      tick();
      wren_ram = 1'b0;
      tick();
      checks++; if (q_ram !== 16'h1234) begin errors++; $display("FAIL rd_old got %h exp 1234", q_ram); end
      tick();
      checks++; if (q_ram !== 16'h5678) begin errors++; $display("FAIL rd_new got %h exp 5678", q_ram); end
   endtask

   task automatic test_mmio();
      logic [15:0] d, exp;
      cpu_write(16'hFFF0, 16'h00AB);
      checks++; if (SEG1 !== 16'h00AB) begin errors++; $display("FAIL seg1_wr got %h exp 00ab", SEG1); end
      cpu_write(16'hFFF1, 16'h00CD);
      checks++; if (SEG2 !== 16'h00CD) begin errors++; $display("FAIL seg2_wr got %h exp 00cd", SEG2); end
      cpu_write(16'hFFF2, 16'hDEAD);
      exp = cyc_m;
      cpu_read(16'hFFF2, d);
      checks++; if (d !== exp) begin errors++; $display("FAIL cyc_ro got %h exp %h", d, exp); end
      cpu_read(16'hFFF0, d);
      checks++; if (d !== 16'h00AB) begin errors++; $display("FAIL seg1_rd got %h exp 00ab", d); end
      cpu_write(16'hFFF7, 16'h1234);
      cpu_read(16'hFFF7, d);
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL ofs7_rd got %h exp 0000", d); end
   endtask

   task automatic test_host();
      logic [15:0] d;
      int lat;
      host_xact(1'b1, 16'h0010, 16'hBEEF, d, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL host_wr_lat got %0d exp 2", lat); end
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b exp 0", host_ack); end
      cpu_read(16'h0010, d);
      checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL cpu_rd_host got %h exp beef", d); end
      host_xact(1'b0, 16'h0010, 16'h0000, d, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL host_rd_lat got %0d exp 2", lat); end
      checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL host_rd got %h exp beef", d); end
   endtask

   task automatic test_collision();
      logic [15:0] d;
      logic ack;
      host_with_cpu(1'b1, 16'h0020, 16'h2222, 16'h0020, 16'h1111, ack, d);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL col_ack got %b exp 1", ack); end
      cpu_read(16'h0020, d);
      checks++; if (d !== 16'h1111) begin errors++; $display("FAIL col_ram got %h exp 1111", d); end
      host_with_cpu(1'b1, 16'hFFF3, 16'h2222, 16'hFFF3, 16'h1111, ack, d);
      cpu_read(16'hFFF3, d);
      checks++; if (d !== 16'h1111) begin errors++; $display("FAIL col_mbox got %h exp 1111", d); end
      cpu_write(16'h0030, 16'h3333);
      host_with_cpu(1'b0, 16'h0030, 16'h0000, 16'h0030, 16'h4444, ack, d);
      checks++; if (d !== 16'h3333) begin errors++; $display("FAIL col_hrd_old got %h exp 3333", d); end
      cpu_read(16'h0030, d);
      checks++; if (d !== 16'h4444) begin errors++; $display("FAIL col_cpu_new got %h exp 4444", d); end
   endtask

   task automatic test_mailbox();
      logic [15:0] d, exp;
      int lat;
      host_xact(1'b1, 16'hFFF3, 16'h5A5A, d, lat);
      cpu_read(16'hFFF3, d);
      checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL mbox_cpu got %h exp 5a5a", d); end
      cpu_read(16'hFFF7, d);
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL mbox_ofs7 got %h exp 0000", d); end
      host_xact(1'b0, 16'hFFF3, 16'h0000, d, lat);
      checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL mbox_host got %h exp 5a5a", d); end
      host_we = 1'b0;
      host_addr = 16'hFFF2;
      host_req = 1'b1;
      tick();
      exp = cyc_m;
      tick();
      checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL cyc_host_ack got %b exp 1", host_ack); end
      checks++; if (host_rdata !== exp) begin errors++; $display("FAIL cyc_host got %h exp %h", host_rdata, exp); end
      host_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [4:0] pat;
      logic [4:0] exp_pat;
      exp_pat = 5'b10010;
      host_we = 1'b0;
      host_addr = 16'h0005;
      host_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         pat[i] = host_ack;
      end
      host_req = 1'b0;
      tick();
      tick();
      checks++; if (pat !== exp_pat) begin errors++; $display("FAIL b2b_ack got %b exp %b", pat, exp_pat); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      int acks = 0;
      cpu_write(16'h0040, 16'h1234);
      host_we = 1'b1;
      host_addr = 16'h0040;
      host_wdata = 16'h7777;
      host_req = 1'b1;
      tick();
      reset = 1'b1;
      host_req = 1'b0;
      tick();
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL abort_ack got %b exp 0", host_ack); end
      reset = 1'b0;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         if (host_ack) acks++;
      end
      checks++; if (acks !== 0) begin errors++; $display("FAIL abort_noack got %0d exp 0", acks); end
      cpu_read(16'h0040, d);
      checks++; if (d !== EXP_ABORT) begin errors++; $display("FAIL abort_ram got %h exp %h", d, EXP_ABORT); end
   endtask

`ifdef STACK_RAM_CLEAR_EN
   task automatic test_clear();
      logic [15:0] d;
      int n;
      int lat;
      int bad = 0;
      for (int i = 0; i < 16; i++) cpu_write(16'(i), 16'hFFFF);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      address_ram = 16'h000F;
      n = 0;
      tick(); n++;
      tick(); n++;
      checks++; if (q_ram !== 16'h0) begin errors++; $display("FAIL clr_cpu_rd got %h exp 0000", q_ram); end
      address_ram = 16'h0000;
      data_ram = 16'hFFFF;
      wren_ram = 1'b1;
      tick(); n++;
      wren_ram = 1'b0;
      while (ram_busy && n < 60) begin tick(); n++; end
      checks++; if (n !== 16) begin errors++; $display("FAIL clr_busy_len got %0d exp 16", n); end
      for (int i = 0; i < 16; i++) begin
         cpu_read(16'(i), d);
         if (d !== 16'h0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL clr_words got %0d nonzero exp 0", bad); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 0;
      while (ram_busy && n < 60) begin tick(); n++; end
      checks++; if (n !== 16) begin errors++; $display("FAIL clr_restart got %0d exp 16", n); end
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      host_xact(1'b0, 16'h0003, 16'h0000, d, lat);
      checks++; if (lat !== 18) begin errors++; $display("FAIL clr_host_lat got %0d exp 18", lat); end
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL clr_host_rd got %h exp 0000", d); end
   endtask
`endif

   initial begin
      test_reset();
      test_cpu_ram();
      test_mmio();
      test_host();
      test_collision();
      test_mailbox();
      test_back_to_back();
      test_reset_mid();
`ifdef STACK_RAM_CLEAR_EN
      test_clear();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
